dcache_refill_ctrl: RTL and testbench
=====================================

DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 Parameters SHALL be:
- INDEX_SIZE, 7, set index width (128 sets)
- TAG_SIZE, 20, tag width (addr[31:12])
- BANK_NUM, 8, 32-bit banks per line (addr[4:2] selects the bank)
- BANK_SIZE, 32, bank word width
- TAGV_SIZE, 32, tag-valid entry width
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- miss_req  in  1  level; refill request, miss_addr held until refill_done
- miss_addr  in  32  missing byte address
- refill_done  out  1  one-cycle pulse, line and tag written
- busy  out  1  refill in progress (state != IDLE)
- mem_rd_req  out  1  memory line read request
- mem_rd_addr  out  32  {miss_addr[31:5], 5'b0}
- mem_rd_ack  in  1  request accepted
- mem_rd_valid  in  1  line data valid, one cycle
- mem_rd_data  in  256  line; bank k = bits [32k+31:32k]
- st_valid  in  1  full-word store offered
- st_ready  out  1  store accepted when st_valid && st_ready
- st_addr  in  32  store byte address
- st_data  in  32  merged store word
- bank_we  out  8  per-bank write enable
- bank_waddr  out  7  bank write index
- bank_wdata  out  256  bank k data = bits [32k+31:32k]
- tagv_we  out  1  tag-valid RAM write enable
- tagv_waddr  out  7  tag-valid write index
- tagv_wdata  out  32  {11'b0, 1'b1, tag[19:0]}; bit 20 = valid

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, FILL, DONE.
REQ-004 IDLE: miss_req=1 SHALL latch miss_addr into a line-address register and enter REQ next edge; miss_req in any other state SHALL be ignored.
REQ-005 REQ: mem_rd_req SHALL be 1 and mem_rd_addr SHALL be the latched line address; on an edge with mem_rd_ack=1, go to WAIT.
REQ-006 WAIT: on mem_rd_valid=1, mem_rd_data SHALL be captured into a 256-bit line register and FILL entered; mem_rd_valid outside WAIT SHALL be ignored.
REQ-007 FILL (exactly one cycle):
- bank_we = 8'hFF, bank_waddr = latched addr[11:5], bank_wdata = line register
- tagv_we = 1, tagv_waddr = addr[11:5], tagv_wdata per REQ-002
- next state DONE
REQ-008 DONE: refill_done SHALL be 1 for that cycle only, then IDLE.
REQ-009 Latency: miss_req to mem_rd_req is 1 cycle; mem_rd_valid to FILL is 1 cycle; FILL to refill_done is 1 cycle.
REQ-010 A one-entry store buffer SHALL hold {index, bank, data}; st_ready = !buf_valid || state != FILL.
REQ-011 In every non-FILL cycle with buf_valid=1 the buffer SHALL drain:
- bank_we = one-hot(buf bank), bank_waddr = buf index
- bank_wdata = buf data replicated in all 8 lanes
- tagv_we = 0
REQ-012 A store accepted on edge N SHALL drive its write in the cycle after edge N (or later if stalled by FILL).
REQ-013 Drain and accept in the same cycle SHALL replace the entry without a bubble.
REQ-014 In FILL the refill SHALL own the write port and the buffered store SHALL wait; a store to the same index/bank as the refill SHALL be written in the following cycle, so the store value wins.
REQ-015 When no write is pending, bank_we=0 and tagv_we=0; bank_waddr, bank_wdata, tagv_waddr and tagv_wdata are don't-care.
REQ-016 Stores to a line under refill SHALL NOT be issued by the pipeline before refill_done; the block does no tag check.

Reset
REQ-017 reset=0 SHALL asynchronously force:
- state IDLE, buf_valid 0
- all outputs 0, with st_ready = 1 once reset deasserts
REQ-018 Reset mid-refill SHALL abandon the refill with no FILL write and no refill_done; a late mem_rd_valid after reset SHALL be ignored.

Verification
REQ-019 Refill: miss_addr=0x0000_1234, ack 2 cycles after req, valid 3 cycles later with data = bank k word 0x1000+k -> mem_rd_addr=0x0000_1220, one FILL cycle with bank_we=FF, waddr=0x11, tagv_wdata=0x0010_0001, refill_done on the next cycle.
REQ-020 Store only: st_addr=0x0000_0A48, st_data=0xDEADBEEF in IDLE -> next cycle bank_we=8'h04, bank_waddr=0x52, lane 2 = 0xDEADBEEF.
REQ-021 Store vs FILL: store buffered to index 0x11 bank 1 when FILL begins -> st_ready=0 in FILL, store write the cycle after FILL, final bank-1 word = store data.
REQ-022 Back-to-back stores with st_valid held for 4 cycles -> one write per cycle, no bubble, st_ready=1 throughout.
REQ-023 Reset pulse in WAIT, then mem_rd_valid=1 -> no bank_we or tagv_we, no refill_done, busy=0.
REQ-024 miss_req reasserted in WAIT with a different address -> ignored; mem_rd_addr and FILL index keep the original line address.

Source files
------------

// File: rtl/dcache_refill_ctrl_if.sv
// Purpose: bundles the miss, memory-read, store and RAM-write signals of the refill controller.
// Latency: none, wires only.
// Backpressure: the master drives requests and memory responses; the slave drives st_ready.
interface dcache_refill_ctrl_if #(
  parameter int INDEX_SIZE = 7,
  parameter int BANK_NUM   = 8,
  parameter int BANK_SIZE  = 32,
  parameter int TAGV_SIZE  = 32
);
  logic                          miss_req;
  logic [31:0]                   miss_addr;
  logic                          refill_done;
  logic                          busy;
  logic                          mem_rd_req;
  logic [31:0]                   mem_rd_addr;
  logic                          mem_rd_ack;
  logic                          mem_rd_valid;
  logic [BANK_NUM*BANK_SIZE-1:0] mem_rd_data;
  logic                          st_valid;
  logic                          st_ready;
  logic [31:0]                   st_addr;
  logic [BANK_SIZE-1:0]          st_data;
  logic [BANK_NUM-1:0]           bank_we;
  logic [INDEX_SIZE-1:0]         bank_waddr;
  logic [BANK_NUM*BANK_SIZE-1:0] bank_wdata;
  logic                          tagv_we;
  logic [INDEX_SIZE-1:0]         tagv_waddr;
  logic [TAGV_SIZE-1:0]          tagv_wdata;

  // Pipeline and memory side
  modport master (
    output miss_req, miss_addr, mem_rd_ack, mem_rd_valid, mem_rd_data,
           st_valid, st_addr, st_data,
    input  refill_done, busy, mem_rd_req, mem_rd_addr, st_ready,
           bank_we, bank_waddr, bank_wdata, tagv_we, tagv_waddr, tagv_wdata
  );

  // Refill controller side
  modport slave (
    input  miss_req, miss_addr, mem_rd_ack, mem_rd_valid, mem_rd_data,
           st_valid, st_addr, st_data,
    output refill_done, busy, mem_rd_req, mem_rd_addr, st_ready,
           bank_we, bank_waddr, bank_wdata, tagv_we, tagv_waddr, tagv_wdata
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Purpose: data-cache line refill FSM plus one-entry store buffer sharing the bank write port.
// Latency: miss->mem_rd_req 1 cycle, mem_rd_valid->FILL 1 cycle, FILL->refill_done 1 cycle; store write 1 cycle after accept.
// Backpressure: st_ready drops only while a buffered store is blocked by the FILL write.
module dcache_refill_ctrl #(
  parameter int INDEX_SIZE = 7,
  parameter int TAG_SIZE   = 20,
  parameter int BANK_NUM   = 8,
  parameter int BANK_SIZE  = 32,
  parameter int TAGV_SIZE  = 32
) (
  input logic            clk,
  input logic            reset,
  dcache_refill_ctrl_if.slave bus
);

  localparam int BANK_W = $clog2(BANK_NUM);
  localparam int OFF_W  = BANK_W + 2;
  localparam int LA_W   = 32 - OFF_W;
  localparam int LINE_W = BANK_NUM * BANK_SIZE;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [LA_W-1:0]       line_addr;
  logic [LINE_W-1:0]     line_data;
  logic                  buf_valid;
  logic [INDEX_SIZE-1:0] buf_index;
  logic [BANK_W-1:0]     buf_bank;
  logic [BANK_SIZE-1:0]  buf_data;
  logic                  st_rdy;
  logic                  st_accept;
  logic                  st_drain;
  logic [TAGV_SIZE-1:0]  tagv_entry;

  // Address bits the block never looks at (byte offset, store tag)
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.miss_addr[OFF_W-1:0], bus.st_addr[31:OFF_W+INDEX_SIZE],
                              bus.st_addr[1:0]};

  // The FILL write owns the port, so a buffered store can only leave outside FILL
  assign st_rdy    = reset && (!buf_valid || state != FILL);
  assign st_accept = bus.st_valid && st_rdy;
  assign st_drain  = buf_valid && state != FILL;

  // Tag-valid entry: zero-padded, valid bit just above the tag
  always_comb begin
    tagv_entry                = '0;
    tagv_entry[TAG_SIZE]      = 1'b1;
    tagv_entry[TAG_SIZE-1:0]  = line_addr[LA_W-1:INDEX_SIZE];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode, including the shared bank/tag write port mux
  always_comb begin
    state_nxt       = state;
    bus.busy        = (state != IDLE);
    bus.mem_rd_req  = (state == REQ);
    bus.mem_rd_addr = {line_addr, {OFF_W{1'b0}}};
    bus.refill_done = (state == DONE);
    bus.st_ready    = st_rdy;
    bus.bank_we     = '0;
    bus.bank_waddr  = '0;
    bus.bank_wdata  = '0;
    bus.tagv_we     = 1'b0;
    bus.tagv_waddr  = '0;
    bus.tagv_wdata  = '0;

    case (state)
      IDLE: if (bus.miss_req)     state_nxt = REQ;
      REQ:  if (bus.mem_rd_ack)   state_nxt = WAIT;
      WAIT: if (bus.mem_rd_valid) state_nxt = FILL;
      FILL: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state == FILL) begin
      bus.bank_we    = '1;
      bus.bank_waddr = line_addr[INDEX_SIZE-1:0];
      bus.bank_wdata = line_data;
      bus.tagv_we    = 1'b1;
      bus.tagv_waddr = line_addr[INDEX_SIZE-1:0];
      bus.tagv_wdata = tagv_entry;
    end else if (buf_valid) begin
      bus.bank_we    = {{(BANK_NUM-1){1'b0}}, 1'b1} << buf_bank;
      bus.bank_waddr = buf_index;
      bus.bank_wdata = {BANK_NUM{buf_data}};
    end
  end

  // Line address latched on the accepted miss, line data captured on the memory beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_addr <= '0;
      line_data <= '0;
    end else begin
      if (state == IDLE && bus.miss_req)     line_addr <= bus.miss_addr[31:OFF_W];
      if (state == WAIT && bus.mem_rd_valid) line_data <= bus.mem_rd_data;
    end
  end

  // One-entry store buffer: a new store replaces a draining one without a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_index <= '0;
      buf_bank  <= '0;
      buf_data  <= '0;
    end else if (st_accept) begin
      buf_valid <= 1'b1;
      buf_index <= bus.st_addr[OFF_W+INDEX_SIZE-1:OFF_W];
      buf_bank  <= bus.st_addr[OFF_W-1:2];
      buf_data  <= bus.st_data;
    end else if (st_drain) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Purpose: directed and randomized checks of the refill controller against a transaction-level model.
// Latency: inputs change on the falling edge, outputs are sampled on the following falling edge.
// Backpressure: store acceptance is predicted by the model, memory ack/valid come from the bench.
module tb_dcache_refill_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_refill_ctrl_if bus ();

  dcache_refill_ctrl dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus for the next clock edge
  logic         i_rst, i_miss_req, i_ack, i_valid, i_st_valid;
  logic [31:0]  i_miss_addr, i_st_addr, i_st_data;
  logic [255:0] i_data;

  // Reference model: refill progress flags, latched line, pending store writes in order
  logic         m_active, m_req, m_wait, m_fill, m_done;
  logic [26:0]  m_line;
  logic [255:0] m_data;
  logic [6:0]   q_idx[$];
  logic [2:0]   q_bank[$];
  logic [31:0]  q_dat[$];

  // Shadow of the bank RAM, built from the write port
  logic [31:0] ram [128][8];
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++)
      if (bus.bank_we[k]) ram[bus.bank_waddr][k] <= bus.bank_wdata[32*k +: 32];
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    i_rst = 1'b1; i_miss_req = 1'b0; i_ack = 1'b0; i_valid = 1'b0; i_st_valid = 1'b0;
  endtask

  task automatic model_clear();
    m_active = 0; m_req = 0; m_wait = 0; m_fill = 0; m_done = 0; m_line = '0; m_data = '0;
    q_idx.delete(); q_bank.delete(); q_dat.delete();
  endtask

  // Advance the model across the coming rising edge with the inputs just driven
  task automatic model_update();
    logic rdy, n_active, n_req, n_wait, n_fill, n_done;
    if (!i_rst) begin
      model_clear();
      return;
    end
    rdy = !(m_fill && q_idx.size() != 0);
    if (!m_fill && q_idx.size() != 0) begin
      void'(q_idx.pop_front()); void'(q_bank.pop_front()); void'(q_dat.pop_front());
    end
    if (i_st_valid && rdy) begin
      q_idx.push_back(i_st_addr[11:5]); q_bank.push_back(i_st_addr[4:2]); q_dat.push_back(i_st_data);
    end
    n_active = m_active ? !m_done : i_miss_req;
    n_req    = m_req ? !i_ack : (!m_active && i_miss_req);
    n_wait   = m_wait ? !i_valid : (m_req && i_ack);
    n_fill   = m_wait && i_valid;
    n_done   = m_fill;
    if (!m_active && i_miss_req) m_line = i_miss_addr[31:5];
    if (n_fill) m_data = i_data;
    m_active = n_active; m_req = n_req; m_wait = n_wait; m_fill = n_fill; m_done = n_done;
  endtask

  task automatic model_check();
    if (!rst_n) begin
      chk("rst_ctl", {bus.busy, bus.mem_rd_req, bus.refill_done, bus.st_ready, bus.tagv_we, bus.bank_we}, '0);
      chk("rst_addr", {bus.mem_rd_addr, bus.bank_waddr, bus.tagv_waddr, bus.tagv_wdata}, '0);
      chk("rst_wdata", bus.bank_wdata, '0);
      return;
    end
    chk("busy", bus.busy, m_active);
    chk("mem_rd_req", bus.mem_rd_req, m_req);
    chk("refill_done", bus.refill_done, m_done);
    chk("st_ready", bus.st_ready, !(m_fill && q_idx.size() != 0));
    if (m_req) chk("mem_rd_addr", bus.mem_rd_addr, {m_line, 5'b0});
    if (m_fill) begin
      chk("fill_we", bus.bank_we, 8'hFF);
      chk("fill_waddr", bus.bank_waddr, m_line[6:0]);
      chk("fill_wdata", bus.bank_wdata, m_data);
      chk("fill_tagv_we", bus.tagv_we, 1'b1);
      chk("fill_tagv_waddr", bus.tagv_waddr, m_line[6:0]);
      chk("fill_tagv_wdata", bus.tagv_wdata, {11'b0, 1'b1, m_line[26:7]});
    end else if (q_idx.size() != 0) begin
      chk("st_we", bus.bank_we, 8'd1 << q_bank[0]);
      chk("st_waddr", bus.bank_waddr, q_idx[0]);
      chk("st_wdata", bus.bank_wdata, {8{q_dat[0]}});
      chk("st_tagv_we", bus.tagv_we, 1'b0);
    end else begin
      chk("idle_we", {bus.tagv_we, bus.bank_we}, '0);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, sample on the next falling edge
  task automatic tick();
    rst_n            = i_rst;
    bus.miss_req     = i_miss_req;
    bus.miss_addr    = i_miss_addr;
    bus.mem_rd_ack   = i_ack;
    bus.mem_rd_valid = i_valid;
    bus.mem_rd_data  = i_data;
    bus.st_valid     = i_st_valid;
    bus.st_addr      = i_st_addr;
    bus.st_data      = i_st_data;
    model_update();
    @(negedge clk);
    model_check();
  endtask

  initial begin
    clr();
    i_rst = 1'b0; i_miss_addr = '0; i_st_addr = '0; i_st_data = '0; i_data = '0;
    bus.miss_req = 0; bus.miss_addr = '0; bus.mem_rd_ack = 0; bus.mem_rd_valid = 0;
    bus.mem_rd_data = '0; bus.st_valid = 0; bus.st_addr = '0; bus.st_data = '0;
    model_clear();
    @(negedge clk);
    model_check();
    clr(); tick();
    chk("post_rst_st_ready", bus.st_ready, 1'b1);

    // Basic refill with delayed ack and data
    i_miss_req = 1; i_miss_addr = 32'h0000_1234; tick();
    chk("r19_req", bus.mem_rd_req, 1'b1);
    chk("r19_addr", bus.mem_rd_addr, 32'h0000_1220);
    i_miss_req = 0; tick();
    i_ack = 1; tick(); i_ack = 0;
    tick(); tick();
    for (int k = 0; k < 8; k++) i_data[32*k +: 32] = 32'h1000 + k;
    i_valid = 1; tick(); i_valid = 0;
    chk("r19_fill_we", bus.bank_we, 8'hFF);
    chk("r19_fill_waddr", bus.bank_waddr, 7'h11);
    chk("r19_tagv_wdata", bus.tagv_wdata, 32'h0010_0001);
    chk("r19_fill_done0", bus.refill_done, 1'b0);
    tick();
    chk("r19_done", bus.refill_done, 1'b1);
    chk("r19_ram_b3", ram[7'h11][3], 32'h1003);
    tick();
    chk("r19_idle_busy", bus.busy, 1'b0);

    // Lone store in IDLE
    i_st_valid = 1; i_st_addr = 32'h0000_0A48; i_st_data = 32'hDEADBEEF; tick(); i_st_valid = 0;
    chk("r20_we", bus.bank_we, 8'h04);
    chk("r20_waddr", bus.bank_waddr, 7'h52);
    chk("r20_lane2", bus.bank_wdata[95:64], 32'hDEADBEEF);
    tick();

    // Store to the refilled bank buffered as FILL begins
    i_miss_req = 1; i_miss_addr = 32'h0000_1234; tick(); i_miss_req = 0;
    i_ack = 1; tick(); i_ack = 0;
    i_valid = 1; i_st_valid = 1; i_st_addr = 32'h0000_1224; i_st_data = 32'hCAFEF00D; tick();
    i_valid = 0; i_st_valid = 0;
    chk("r21_fill_rdy", bus.st_ready, 1'b0);
    chk("r21_fill_we", bus.bank_we, 8'hFF);
    tick();
    chk("r21_st_we", bus.bank_we, 8'h02);
    chk("r21_st_lane1", bus.bank_wdata[63:32], 32'hCAFEF00D);
    tick();
    chk("r21_ram_b1", ram[7'h11][1], 32'hCAFEF00D);
    chk("r21_ram_b2", ram[7'h11][2], 32'h1002);

    // Back-to-back stores
    for (int i = 0; i < 4; i++) begin
      i_st_valid = 1; i_st_addr = 32'h400 + 32'(i) * 36; i_st_data = 32'hA000 + 32'(i); tick();
      chk("r22_rdy", bus.st_ready, 1'b1);
      chk("r22_we", bus.bank_we, 8'd1 << i);
      chk("r22_waddr", bus.bank_waddr, 7'h20 + 7'(i));
    end
    i_st_valid = 0; tick();

    // Reset during WAIT, then a late data beat
    i_miss_req = 1; i_miss_addr = 32'h0000_5000; tick(); i_miss_req = 0;
    i_ack = 1; tick(); i_ack = 0;
    i_rst = 0; tick();
    i_rst = 1; i_valid = 1; tick(); i_valid = 0;
    chk("r23_busy", bus.busy, 1'b0);
    chk("r23_we", {bus.tagv_we, bus.bank_we}, '0);
    tick();
    chk("r23_done", bus.refill_done, 1'b0);
    chk("r23_we2", {bus.tagv_we, bus.bank_we}, '0);

    // Second miss during WAIT is ignored
    i_miss_req = 1; i_miss_addr = 32'h0003_2460; tick(); i_miss_req = 0;
    chk("r24_addr", bus.mem_rd_addr, 32'h0003_2460);
    i_ack = 1; tick(); i_ack = 0;
    i_miss_req = 1; i_miss_addr = 32'h0009_87C0; tick();
    chk("r24_req", bus.mem_rd_req, 1'b0);
    i_valid = 1; tick(); i_valid = 0; i_miss_req = 0;
    chk("r24_waddr", bus.bank_waddr, 7'h23);
    chk("r24_tagv", bus.tagv_wdata, 32'h0010_0032);
    tick(); tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      i_rst       = ($urandom_range(0, 199) != 0);
      i_miss_req  = ($urandom_range(0, 3) == 0);
      i_miss_addr = $urandom;
      i_ack       = m_req && ($urandom_range(0, 2) == 0);
      i_valid     = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 8; k++) i_data[32*k +: 32] = $urandom;
      i_st_valid  = ($urandom_range(0, 1) == 0);
      i_st_addr   = $urandom;
      i_st_data   = $urandom;
      tick();
    end
    clr(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
